lenet_avmm_sequencer: RTL and testbench

- Avalon-MM master: the initiator side of the classifier's control slave.
- Replaces NIOS II software polling for batch runs. Walks a range of graph indices and, for each one: writes the graph register, asserts start, waits for lenet finish, reads the result register, then deasserts start.
- Results stream out on a simple write port into a result RAM/FIFO owned by the integrator.
- Sits between a control CSR (go/range) and the classifier slave on the same clk domain.

---
 rtl/lenet_avmm_sequencer.sv | 213 +++++++++++++++++++++
 tb/tb_lenet_avmm_sequencer.sv | 308 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/lenet_avmm_sequencer.sv
// lenet_avmm_sequencer
// Avalon-MM master that drives the LeNet classifier control slave for batch
// runs. For every graph index from first_graph to last_graph (inclusive) it
// writes the graph register, raises start, waits for lenet_finish_i (or a
// timeout), reads the result register, then drops start. Each result goes out
// on a one-cycle write strobe to a result RAM/FIFO.
//
// Ports
//   clk, reset_n          system clock, asynchronous active-low reset
//   go                    one-cycle batch start (ignored while busy)
//   first_graph/last_graph inclusive 5-bit graph index range
//   avm_*                 Avalon-MM master (address, chipselect, write, read,
//                         writedata, waitrequest, readdata)
//   lenet_finish_i        classifier-complete level
//   busy, done            batch in progress / one-cycle end-of-batch pulse
//   res_we/res_index/res_value  result stream (8'hFF marks a timeout)
//   timeout_err           sticky timeout flag, cleared by an accepted go
module lenet_avmm_sequencer #(
    parameter int TIMEOUT_CYC = 4096,
    parameter int RD_LAT      = 1
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       go,
    input  logic [4:0] first_graph,
    input  logic [4:0] last_graph,
    output logic [1:0] avm_address,
    output logic       avm_chipselect,
    output logic       avm_write,
    output logic       avm_read,
    output logic [7:0] avm_writedata,
    input  logic       avm_waitrequest,
    input  logic [7:0] avm_readdata,
    input  logic       lenet_finish_i,
    output logic       busy,
    output logic       done,
    output logic       res_we,
    output logic [4:0] res_index,
    output logic [7:0] res_value,
    output logic       timeout_err
);

    // One counter serves both the finish timeout and the read-latency wait.
    localparam int CW = $clog2((TIMEOUT_CYC > RD_LAT) ? TIMEOUT_CYC : RD_LAT) + 1;
    localparam logic [CW-1:0] TMO_LAST = CW'(TIMEOUT_CYC - 1);
    localparam logic [CW-1:0] RD_LAST  = CW'(RD_LAT - 1);

    typedef enum logic [2:0] {
        IDLE,
        WR_GRAPH,
        WR_START1,
        WAIT_FIN,
        RD_RES,
        RD_WAIT,
        WR_START0,
        FIN
    } state_t;

    state_t          state_q, state_d;
    logic [4:0]      cur_q, cur_d;
    logic [4:0]      last_q, last_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            res_we_q, res_we_d;
    logic [4:0]      res_index_q, res_index_d;
    logic [7:0]      res_value_q, res_value_d;
    logic            tmo_q, tmo_d;
    logic            accept;

    assign accept = (avm_write | avm_read) & ~avm_waitrequest;

    // State and datapath registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            cur_q       <= '0;
            last_q      <= '0;
            cnt_q       <= '0;
            res_we_q    <= 1'b0;
            res_index_q <= '0;
            res_value_q <= '0;
            tmo_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            cur_q       <= cur_d;
            last_q      <= last_d;
            cnt_q       <= cnt_d;
            res_we_q    <= res_we_d;
            res_index_q <= res_index_d;
            res_value_q <= res_value_d;
            tmo_q       <= tmo_d;
        end
    end

    // Next-state and datapath update.
    always_comb begin
        state_d     = state_q;
        cur_d       = cur_q;
        last_d      = last_q;
        cnt_d       = cnt_q;
        res_we_d    = 1'b0;
        res_index_d = res_index_q;
        res_value_d = res_value_q;
        tmo_d       = tmo_q;
        unique case (state_q)
            IDLE: begin
                if (go) begin
                    cur_d   = first_graph;
                    last_d  = last_graph;
                    tmo_d   = 1'b0;
                    state_d = (first_graph > last_graph) ? FIN : WR_GRAPH;
                end
            end
            WR_GRAPH: begin
                if (accept) state_d = WR_START1;
            end
            WR_START1: begin
                if (accept) begin
                    cnt_d   = '0;
                    state_d = WAIT_FIN;
                end
            end
            WAIT_FIN: begin
                // Finish has priority over a timeout expiring on the same cycle.
                if (lenet_finish_i) begin
                    state_d = RD_RES;
                end else if (cnt_q == TMO_LAST) begin
                    tmo_d       = 1'b1;
                    res_we_d    = 1'b1;
                    res_index_d = cur_q;
                    res_value_d = 8'hFF;
                    state_d     = WR_START0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            RD_RES: begin
                if (accept) begin
                    cnt_d   = '0;
                    state_d = RD_WAIT;
                end
            end
            RD_WAIT: begin
                if (cnt_q == RD_LAST) begin
                    res_we_d    = 1'b1;
                    res_index_d = cur_q;
                    res_value_d = avm_readdata;
                    state_d     = WR_START0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            WR_START0: begin
                // Equality test against last keeps last=31 from wrapping.
                if (accept) begin
                    if (cur_q == last_q) begin
                        state_d = FIN;
                    end else begin
                        cur_d   = cur_q + 1'b1;
                        state_d = WR_GRAPH;
                    end
                end
            end
            FIN: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Bus and status outputs decode the state only, so an async reset drops
    // every strobe immediately and they stay stable while stalled.
    always_comb begin
        avm_address   = 2'd0;
        avm_write     = 1'b0;
        avm_read      = 1'b0;
        avm_writedata = 8'h00;
        busy          = (state_q != IDLE);
        done          = (state_q == FIN);
        unique case (state_q)
            WR_GRAPH: begin
                avm_write     = 1'b1;
                avm_address   = 2'd0;
                avm_writedata = {3'b000, cur_q};
            end
            WR_START1: begin
                avm_write     = 1'b1;
                avm_address   = 2'd1;
                avm_writedata = 8'h01;
            end
            RD_RES: begin
                avm_read    = 1'b1;
                avm_address = 2'd2;
            end
            WR_START0: begin
                avm_write     = 1'b1;
                avm_address   = 2'd1;
                avm_writedata = 8'h00;
            end
            default: begin
                avm_address = 2'd0;
            end
        endcase
        avm_chipselect = avm_write | avm_read;
    end

    assign res_we      = res_we_q;
    assign res_index   = res_index_q;
    assign res_value   = res_value_q;
    assign timeout_err = tmo_q;

endmodule

// File: tb/tb_lenet_avmm_sequencer.sv
// tb_lenet_avmm_sequencer
// Directed bench for lenet_avmm_sequencer with TIMEOUT_CYC=16, RD_LAT=1.
// A small slave model on the falling edge answers the Avalon bus (optional
// waitrequest stalls, read data one cycle after accept), drives
// lenet_finish_i a fixed delay after each start=1 write, and logs every
// accepted transfer and result strobe for the directed checks.
module tb_lenet_avmm_sequencer;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       go = 1'b0;
    logic [4:0] first_graph = '0;
    logic [4:0] last_graph = '0;
    logic [1:0] avm_address;
    logic       avm_chipselect;
    logic       avm_write;
    logic       avm_read;
    logic [7:0] avm_writedata;
    logic       avm_waitrequest = 1'b0;
    logic [7:0] avm_readdata = 8'h00;
    logic       lenet_finish_i = 1'b0;
    logic       busy;
    logic       done;
    logic       res_we;
    logic [4:0] res_index;
    logic [7:0] res_value;
    logic       timeout_err;

    lenet_avmm_sequencer #(.TIMEOUT_CYC(16), .RD_LAT(1)) dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .go             (go),
        .first_graph    (first_graph),
        .last_graph     (last_graph),
        .avm_address    (avm_address),
        .avm_chipselect (avm_chipselect),
        .avm_write      (avm_write),
        .avm_read       (avm_read),
        .avm_writedata  (avm_writedata),
        .avm_waitrequest(avm_waitrequest),
        .avm_readdata   (avm_readdata),
        .lenet_finish_i (lenet_finish_i),
        .busy           (busy),
        .done           (done),
        .res_we         (res_we),
        .res_index      (res_index),
        .res_value      (res_value),
        .timeout_err    (timeout_err)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;

    // Stimulus knobs written by the initial block only.
    int         stallCycles = 0;
    int         finDelay = 0;
    logic [7:0] rdMem [64];

    // Model state written by the slave process only.
    int          cycleNum = 0;
    int          rdPtr = 0;
    int          finCnt = 0;
    int          stallCnt = 0;
    logic        pendRead = 1'b0;
    logic [11:0] snap = '0;
    logic [11:0] curX;
    int          stableViol = 0;
    int          csViol = 0;
    int          csCount = 0;
    int          busyCount = 0;
    int          doneCount = 0;
    int          doneCycle = 0;
    int          goCycle = 0;
    int          startAccCycle = 0;
    int          startAccCount = 0;
    int          resWeCycle = 0;
    logic [11:0] xferLog [$];
    logic [12:0] resLog [$];

    // Slave model: transfer word is {read, write, address, writedata}.
    always @(negedge clk) begin
        if (!reset_n) begin
            avm_waitrequest = 1'b0;
            pendRead        = 1'b0;
            stallCnt        = 0;
            finCnt          = 0;
            lenet_finish_i  = 1'b0;
        end else begin
            cycleNum++;
            if (pendRead) begin
                avm_readdata = rdMem[rdPtr % 64];
                rdPtr++;
                pendRead = 1'b0;
            end
            if (finCnt > 0) begin
                finCnt--;
                if (finCnt == 0) lenet_finish_i = 1'b1;
            end
            if (avm_chipselect !== (avm_write | avm_read)) csViol++;
            if (avm_chipselect) csCount++;
            if (busy) busyCount++;
            if (done) begin
                doneCount++;
                doneCycle = cycleNum;
            end
            if (go) goCycle = cycleNum;
            if (res_we) begin
                resLog.push_back({res_index, res_value});
                resWeCycle = cycleNum;
            end
            curX = {avm_read, avm_write, avm_address, (avm_read ? 8'h00 : avm_writedata)};
            if (avm_write | avm_read) begin
                if (stallCnt > 0 && curX !== snap) stableViol++;
                if (stallCnt == 0) snap = curX;
                if (stallCnt < stallCycles) begin
                    avm_waitrequest = 1'b1;
                    stallCnt++;
                end else begin
                    avm_waitrequest = 1'b0;
                    stallCnt = 0;
                    xferLog.push_back(curX);
                    if (avm_read) pendRead = 1'b1;
                    if (avm_write && avm_address == 2'd1) begin
                        if (avm_writedata == 8'h01) begin
                            startAccCycle = cycleNum;
                            startAccCount++;
                            if (finDelay > 0) finCnt = finDelay;
                        end else begin
                            lenet_finish_i = 1'b0;
                        end
                    end
                end
            end else begin
                avm_waitrequest = 1'b0;
                stallCnt = 0;
            end
        end
    end

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic applyStimulus(input logic [4:0] f, input logic [4:0] l, input int stall, input int fd);
        stallCycles = stall;
        finDelay    = fd;
        @(posedge clk);
        #1;
        first_graph = f;
        last_graph  = l;
        go          = 1'b1;
        @(posedge clk);
        #1;
        go = 1'b0;
    endtask

    task automatic waitDone(input string tag, input int target, input int maxCyc);
        for (int i = 0; i < maxCyc && doneCount < target; i++) @(posedge clk);
        checkOutput(tag, 32'(doneCount >= target), 32'd1);
        repeat (2) @(posedge clk);
    endtask

    task automatic loadRead(input logic [7:0] a, input logic [7:0] b, input logic [7:0] c);
        rdMem[rdPtr % 64]       = a;
        rdMem[(rdPtr + 1) % 64] = b;
        rdMem[(rdPtr + 2) % 64] = c;
    endtask

    task automatic checkBatch35(input string tag, input int xBase, input int rBase, input int dBase);
        logic [11:0] expX [12];
        logic [12:0] expR [3];
        expX = '{12'h403, 12'h501, 12'hA00, 12'h500,
                 12'h404, 12'h501, 12'hA00, 12'h500,
                 12'h405, 12'h501, 12'hA00, 12'h500};
        expR = '{{5'd3, 8'h07}, {5'd4, 8'h02}, {5'd5, 8'h09}};
        checkOutput({tag, "_xfer_n"}, 32'(xferLog.size() - xBase), 32'd12);
        for (int i = 0; i < 12; i++)
            checkOutput($sformatf("%s_xfer%0d", tag, i), 32'(xferLog[xBase + i]), 32'(expX[i]));
        checkOutput({tag, "_res_n"}, 32'(resLog.size() - rBase), 32'd3);
        for (int i = 0; i < 3; i++)
            checkOutput($sformatf("%s_res%0d", tag, i), 32'(resLog[rBase + i]), 32'(expR[i]));
        checkOutput({tag, "_done_n"}, 32'(doneCount - dBase), 32'd1);
        checkOutput({tag, "_tmo"}, 32'(timeout_err), 32'd0);
    endtask

    initial begin
        int xBase, rBase, dBase, bBase, cBase, sBase;

        $display("[TB] start");

        // Reset state: every output zero.
        #12;
        checkOutput("rst_busy", 32'(busy), 32'd0);
        checkOutput("rst_done", 32'(done), 32'd0);
        checkOutput("rst_cs", 32'(avm_chipselect), 32'd0);
        checkOutput("rst_wr_rd", 32'({avm_write, avm_read}), 32'd0);
        checkOutput("rst_addr_data", 32'({avm_address, avm_writedata}), 32'd0);
        checkOutput("rst_res", 32'({res_we, res_index, res_value}), 32'd0);
        checkOutput("rst_tmo", 32'(timeout_err), 32'd0);
        @(posedge clk);
        #1;
        reset_n = 1'b1;

        // Range 3..5, no stalls, finish 10 cycles after each start.
        xBase = xferLog.size(); rBase = resLog.size(); dBase = doneCount;
        loadRead(8'h07, 8'h02, 8'h09);
        applyStimulus(5'd3, 5'd5, 0, 10);
        waitDone("b1_done_wait", dBase + 1, 500);
        checkBatch35("b1", xBase, rBase, dBase);
        checkOutput("b1_cs_rule", 32'(csViol), 32'd0);

        // Same range with 4 stall cycles on every transfer.
        xBase = xferLog.size(); rBase = resLog.size(); dBase = doneCount;
        loadRead(8'h07, 8'h02, 8'h09);
        applyStimulus(5'd3, 5'd5, 4, 10);
        waitDone("b2_done_wait", dBase + 1, 1000);
        checkBatch35("b2", xBase, rBase, dBase);
        checkOutput("b2_stable", 32'(stableViol), 32'd0);
        checkOutput("b2_cs_rule", 32'(csViol), 32'd0);

        // Timeout: finish never rises, range 0..0.
        xBase = xferLog.size(); rBase = resLog.size(); dBase = doneCount;
        applyStimulus(5'd0, 5'd0, 0, 0);
        waitDone("to_done_wait", dBase + 1, 200);
        checkOutput("to_res_n", 32'(resLog.size() - rBase), 32'd1);
        checkOutput("to_res0", 32'(resLog[rBase]), 32'({5'd0, 8'hFF}));
        checkOutput("to_latency", 32'(resWeCycle - startAccCycle), 32'd17);
        checkOutput("to_xfer_n", 32'(xferLog.size() - xBase), 32'd3);
        checkOutput("to_xfer0", 32'(xferLog[xBase]), 32'h400);
        checkOutput("to_xfer1", 32'(xferLog[xBase + 1]), 32'h501);
        checkOutput("to_xfer2", 32'(xferLog[xBase + 2]), 32'h500);
        checkOutput("to_tmo", 32'(timeout_err), 32'd1);
        checkOutput("to_done_n", 32'(doneCount - dBase), 32'd1);

        // Empty range 7..2: FIN only, no bus, also clears timeout_err.
        dBase = doneCount; bBase = busyCount; cBase = csCount;
        applyStimulus(5'd7, 5'd2, 0, 10);
        waitDone("er_done_wait", dBase + 1, 50);
        checkOutput("er_done_n", 32'(doneCount - dBase), 32'd1);
        checkOutput("er_done_lat", 32'(doneCycle - goCycle), 32'd1);
        checkOutput("er_busy_cyc", 32'(busyCount - bBase), 32'd1);
        checkOutput("er_cs_cyc", 32'(csCount - cBase), 32'd0);
        checkOutput("er_tmo_clr", 32'(timeout_err), 32'd0);

        // go pulsed mid-batch must be ignored.
        xBase = xferLog.size(); rBase = resLog.size(); dBase = doneCount; sBase = startAccCount;
        loadRead(8'h11, 8'h22, 8'h33);
        applyStimulus(5'd1, 5'd2, 0, 10);
        for (int i = 0; i < 100 && startAccCount == sBase; i++) @(posedge clk);
        repeat (3) @(posedge clk);
        #1;
        first_graph = 5'd10;
        last_graph  = 5'd20;
        go          = 1'b1;
        @(posedge clk);
        #1;
        go = 1'b0;
        waitDone("mg_done_wait", dBase + 1, 500);
        checkOutput("mg_res_n", 32'(resLog.size() - rBase), 32'd2);
        checkOutput("mg_res0", 32'(resLog[rBase]), 32'({5'd1, 8'h11}));
        checkOutput("mg_res1", 32'(resLog[rBase + 1]), 32'({5'd2, 8'h22}));
        checkOutput("mg_xfer_n", 32'(xferLog.size() - xBase), 32'd8);
        checkOutput("mg_done_n", 32'(doneCount - dBase), 32'd1);

        // Async reset while waiting for finish.
        rBase = resLog.size(); sBase = startAccCount;
        applyStimulus(5'd6, 5'd8, 0, 0);
        for (int i = 0; i < 100 && startAccCount == sBase; i++) @(posedge clk);
        checkOutput("ar_start_seen", 32'(startAccCount - sBase), 32'd1);
        repeat (4) @(posedge clk);
        #3;
        reset_n = 1'b0;
        #1;
        checkOutput("ar_busy", 32'(busy), 32'd0);
        checkOutput("ar_strobes", 32'({avm_chipselect, avm_write, avm_read}), 32'd0);
        checkOutput("ar_addr_data", 32'({avm_address, avm_writedata}), 32'd0);
        checkOutput("ar_res", 32'({res_we, res_index, res_value}), 32'd0);
        checkOutput("ar_tmo", 32'(timeout_err), 32'd0);
        repeat (2) @(posedge clk);
        #1;
        reset_n = 1'b1;
        checkOutput("ar_no_res", 32'(resLog.size() - rBase), 32'd0);

        // Range 31..31 after reset: one result, no wrap.
        xBase = xferLog.size(); rBase = resLog.size(); dBase = doneCount;
        loadRead(8'h5A, 8'h00, 8'h00);
        applyStimulus(5'd31, 5'd31, 0, 10);
        waitDone("g31_done_wait", dBase + 1, 200);
        checkOutput("g31_res_n", 32'(resLog.size() - rBase), 32'd1);
        checkOutput("g31_res0", 32'(resLog[rBase]), 32'({5'd31, 8'h5A}));
        checkOutput("g31_xfer_n", 32'(xferLog.size() - xBase), 32'd4);
        checkOutput("g31_xfer0", 32'(xferLog[xBase]), 32'h41F);
        checkOutput("g31_xfer1", 32'(xferLog[xBase + 1]), 32'h501);
        checkOutput("g31_xfer2", 32'(xferLog[xBase + 2]), 32'hA00);
        checkOutput("g31_xfer3", 32'(xferLog[xBase + 3]), 32'h500);
        checkOutput("g31_busy_end", 32'(busy), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
